multicycle_ctrl: RTL

Multicycle control sequencer for the LEGv8-subset execution datapath. It fetches an instruction over a req/ack handshake, latches and decodes it, and drives the execution-stage controls (ALUSrc, ALUOp, B/BZ/BNZ, MemRead/MemWrite/MemtoReg/RegWrite) state by state. It stalls on the data-memory handshake and pulses PC-update strobes. It sits between the instruction/data memories and the Execution/MemoryAccess datapath, replacing free-running combinational control.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/ctrl_decode.sv | 63 ++++++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle LEGv8-subset controller.
// ALUSrc/ALUOp encodings are also consumed by ALUControl in the datapath.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    RTYPE   = 3'd0,
    ADDI    = 3'd1,
    LDUR    = 3'd2,
    STUR    = 3'd3,
    CBZ     = 3'd4,
    CBNZ    = 3'd5,
    BR      = 3'd6,
    ILLEGAL = 3'd7
  } iclass_t;

  // Opcode fields, each aligned to the top of ir.
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam logic [1:0] ALUSRC_DATA2 = 2'b00;
  localparam logic [1:0] ALUSRC_SEXT  = 2'b01;
  localparam logic [1:0] ALUSRC_IMM12 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASS  = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] alusrc;
    logic [1:0] aluop;
    logic       b;
    logic       bz;
    logic       bnz;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: top 11 bits of ir -> instruction class
// and execution control bundle. Immediate fields go to the datapath via ir.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [10:0] op,
  output logic [2:0]  iclass,
  output logic [1:0]  alusrc,
  output logic [1:0]  aluop,
  output logic        b,
  output logic        bz,
  output logic        bnz
);

  iclass_t cls;

  // Priority order matters: the short opcodes are matched before the 11-bit ones.
  always_comb begin
    cls = ILLEGAL;
    if (op[10:5] == OP_B)
      cls = BR;
    else if (op[10:3] == OP_CBZ)
      cls = CBZ;
    else if (op[10:3] == OP_CBNZ)
      cls = CBNZ;
    else if (op[10:1] == OP_ADDI)
      cls = ADDI;
    else begin
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = RTYPE;
        OP_LDUR:                        cls = LDUR;
        OP_STUR:                        cls = STUR;
        default:                        cls = ILLEGAL;
      endcase
    end
  end

  always_comb begin
    alusrc = ALUSRC_DATA2;
    aluop  = ALUOP_ADD;
    b      = 1'b0;
    bz     = 1'b0;
    bnz    = 1'b0;
    case (cls)
      RTYPE:      aluop  = ALUOP_FUNCT;
      ADDI:       alusrc = ALUSRC_IMM12;
      LDUR, STUR: alusrc = ALUSRC_SEXT;
      CBZ: begin
        aluop = ALUOP_PASS;
        bz    = 1'b1;
      end
      CBNZ: begin
        aluop = ALUOP_PASS;
        bnz   = 1'b1;
      end
      BR:         b = 1'b1;
      default:    ;
    endcase
  end

  assign iclass = cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8-subset control sequencer: instruction fetch handshake,
// decode, per-state execution controls, ack timeouts and a retired counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic [31:0] ir,
  input  logic        zero,
  input  logic        dmem_ack,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        B,
  output logic        BZ,
  output logic        BNZ,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        pc_write,
  output logic        pc_src,
  output logic        busy,
  output logic        error,
  output logic [31:0] retired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, nxt;
  iclass_t       cls_q, dec_cls;
  ctrl_t         ctl_q, dec_ctl, ctl_out;
  logic [2:0]    d_cls;
  logic [1:0]    d_alusrc, d_aluop;
  logic          d_b, d_bz, d_bnz;
  logic [CW-1:0] wcnt;
  logic          tmo, pcw_d, pcs_d, err_set;

  ctrl_decode u_dec (
    .op     (ir[31:21]),
    .iclass (d_cls),
    .alusrc (d_alusrc),
    .aluop  (d_aluop),
    .b      (d_b),
    .bz     (d_bz),
    .bnz    (d_bnz)
  );

  assign dec_cls = iclass_t'(d_cls);
  assign dec_ctl = {d_alusrc, d_aluop, d_b, d_bz, d_bnz};
  assign tmo     = (wcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // PC strobes are computed on the edge that leaves the deciding state, so
  // they are pure flops: branch/STUR strobes land in the next FETCH cycle,
  // R-type/ADDI/LDUR strobes land in WB.
  always_comb begin
    nxt     = state;
    pcw_d   = 1'b0;
    pcs_d   = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE:   if (start) nxt = FETCH;
      FETCH: begin
        if (imem_ack) nxt = DECODE;
        else if (tmo) begin
          nxt     = ERR;
          err_set = 1'b1;
        end
      end
      DECODE: begin
        if (dec_cls == ILLEGAL) begin
          nxt     = ERR;
          err_set = 1'b1;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        case (cls_q)
          CBZ, CBNZ, BR: begin
            nxt   = FETCH;
            pcw_d = 1'b1;
            pcs_d = ctl_q.b | (ctl_q.bz & zero) | (ctl_q.bnz & ~zero);
          end
          LDUR, STUR:  nxt = MEM;
          RTYPE, ADDI: begin
            nxt   = WB;
            pcw_d = 1'b1;
          end
          default: begin
            nxt     = ERR;
            err_set = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          nxt   = (cls_q == LDUR) ? WB : FETCH;
          pcw_d = 1'b1;
        end else if (tmo) begin
          nxt     = ERR;
          err_set = 1'b1;
        end
      end
      WB:      nxt = FETCH;
      ERR:     nxt = ERR;
      default: nxt = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir       <= '0;
      cls_q    <= RTYPE;
      ctl_q    <= '0;
      wcnt     <= '0;
      pc_write <= 1'b0;
      pc_src   <= 1'b0;
      error    <= 1'b0;
      retired  <= '0;
    end else begin
      if (state == FETCH && imem_ack) ir <= instr;
      if (state == DECODE) begin
        cls_q <= dec_cls;
        ctl_q <= dec_ctl;
      end
      // Wait counter restarts on each entry to a handshake state.
      if ((nxt == FETCH || nxt == MEM) && nxt != state)
        wcnt <= '0;
      else if ((state == FETCH && !imem_ack) || (state == MEM && !dmem_ack))
        wcnt <= wcnt + CW'(1);
      pc_write <= pcw_d;
      pc_src   <= pcs_d;
      error    <= error | err_set;
      if (pc_write) retired <= retired + 32'd1;
    end
  end

  always_comb begin
    case (state)
      DECODE:        ctl_out = dec_ctl;
      EXEC, MEM, WB: ctl_out = ctl_q;
      default:       ctl_out = '0;
    endcase
    ALUSrc   = ctl_out.alusrc;
    ALUOp    = ctl_out.aluop;
    B        = ctl_out.b;
    BZ       = ctl_out.bz;
    BNZ      = ctl_out.bnz;
    imem_req = (state == FETCH);
    MemRead  = (state == MEM) && (cls_q == LDUR);
    MemWrite = (state == MEM) && (cls_q == STUR);
    RegWrite = (state == WB);
    MemtoReg = (state == WB) && (cls_q == LDUR);
    busy     = (state != IDLE) && (state != ERR);
  end

endmodule
